// File: rtl/frame_parser.sv
// Byte-stream frame parser: SOF, CMD, LEN, payload, XOR checksum, with an inter-byte timeout.
// PayLen is 4 bits wide, so MAX_LEN must not exceed 15.
module frame_parser #(
   parameter logic [7:0] SOF     = 8'hA5,
   parameter int         MAX_LEN = 8,
   parameter int         TIMEOUT = 200000
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [7:0]           RxData,
   input  logic                 RxDone,
   output logic [7:0]           Cmd,
   output logic [8*MAX_LEN-1:0] Payload,
   output logic [3:0]           PayLen,
   output logic                 FrameValid,
   output logic                 FrameErr,
   output logic [1:0]           ErrCode,
   output logic [7:0]           FrameCount
);

   localparam int GW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, GET_CMD, GET_LEN, GET_DATA, GET_CHK} stateT;

   stateT                state, nextState;
   logic                 rxDonePrev;
   logic                 strobe;
   logic                 timeout;
   logic                 acceptFrame;
   logic                 abortFrame;
   logic [1:0]           abortCode;
   logic [GW-1:0]        gapCnt;
   logic [7:0]           cmdShadow;
   logic [3:0]           lenShadow;
   logic [8*MAX_LEN-1:0] payShadow;
   logic [7:0]           xorAcc;
   logic [3:0]           byteCnt;

   assign strobe  = RxDone & ~rxDonePrev;
   assign timeout = (state != IDLE) && (gapCnt == GW'(TIMEOUT - 1));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // A strobe always takes priority over a timeout landing in the same cycle.
   always_comb begin
      nextState   = state;
      acceptFrame = 1'b0;
      abortFrame  = 1'b0;
      abortCode   = 2'b00;
      if (strobe) begin
         case (state)
            IDLE:     if (RxData == SOF) nextState = GET_CMD;
            GET_CMD:  nextState = GET_LEN;
            GET_LEN: begin
               if (RxData == 8'd0) begin
                  nextState = GET_CHK;
               end else if (RxData <= 8'(MAX_LEN)) begin
                  nextState = GET_DATA;
               end else begin
                  abortFrame = 1'b1;
                  abortCode  = 2'b10;
                  nextState  = IDLE;
               end
            end
            GET_DATA: if (byteCnt == lenShadow - 4'd1) nextState = GET_CHK;
            GET_CHK: begin
               if (RxData == xorAcc) begin
                  acceptFrame = 1'b1;
               end else begin
                  abortFrame = 1'b1;
                  abortCode  = 2'b01;
               end
               nextState = IDLE;
            end
            default:  nextState = IDLE;
         endcase
      end else if (timeout) begin
         abortFrame = 1'b1;
         abortCode  = 2'b11;
         nextState  = IDLE;
      end
   end

   // Shadow registers collect the frame in flight; outputs update only on acceptance.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rxDonePrev <= 1'b0;
         gapCnt     <= '0;
         cmdShadow  <= '0;
         lenShadow  <= '0;
         payShadow  <= '0;
         xorAcc     <= '0;
         byteCnt    <= '0;
         Cmd        <= '0;
         Payload    <= '0;
         PayLen     <= '0;
         FrameValid <= 1'b0;
         FrameErr   <= 1'b0;
         ErrCode    <= 2'b00;
         FrameCount <= '0;
      end else begin
         rxDonePrev <= RxDone;
         FrameValid <= acceptFrame;
         FrameErr   <= abortFrame;
         if (abortFrame) ErrCode <= abortCode;
         if (acceptFrame) begin
            Cmd        <= cmdShadow;
            Payload    <= payShadow;
            PayLen     <= lenShadow;
            FrameCount <= FrameCount + 8'd1;
         end
         if (strobe || state == IDLE) gapCnt <= '0;
         else                         gapCnt <= gapCnt + GW'(1);
         if (strobe) begin
            case (state)
               IDLE: begin
                  if (RxData == SOF) begin
                     payShadow <= '0;
                     byteCnt   <= '0;
                  end
               end
               GET_CMD: begin
                  cmdShadow <= RxData;
                  xorAcc    <= RxData;
               end
               GET_LEN: begin
                  lenShadow <= RxData[3:0];
                  xorAcc    <= xorAcc ^ RxData;
                  byteCnt   <= '0;
               end
               GET_DATA: begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     if (byteCnt == 4'(i)) payShadow[8*i +: 8] <= RxData;
                  end
                  xorAcc  <= xorAcc ^ RxData;
                  byteCnt <= byteCnt + 4'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
